muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the execute stage, beside the ALU; fed the same srca/srcb
//  operands from the register file. Executes mult/multu/div/divu over 32 cycles into HI/LO.
//  Serves mfhi/mflo/mthi/mtlo. The controller stalls the datapath while busy=1.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk      in   1      single clock, rising edge
//  reset    in   1      asynchronous, active-high; clears all state
//  start    in   1      launch op; sampled only when not busy
//  op       in   2      00 mult, 01 multu, 10 div, 11 divu
//  a        in   WIDTH  srca: multiplicand / dividend
//  b        in   WIDTH  srcb: multiplier / divisor
//  mthi     in   1      write wdata to HI
//  mtlo     in   1      write wdata to LO
//  wdata    in   WIDTH  data for mthi/mtlo
//  busy     out  1      iteration in progress
//  done     out  1      one-cycle pulse; HI/LO hold the new result
//  dz       out  1      divide-by-zero flag; valid while done=1
//  hi       out  WIDTH  HI register (remainder / upper product)
//  lo       out  WIDTH  LO register (quotient / lower product)
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=0; busy=done=dz=0; counter and working regs = 0.
//   Reset mid-operation aborts the op, with no HI/LO update.
//  FSM: IDLE -> (start) MUL|DIV -> after WIDTH iterations -> DONE -> IDLE.
//   DONE also accepts start with the same rules as IDLE, so back-to-back ops are legal.
//  Timing: start=1 at edge E0 (IDLE/DONE) latches op, |a|, |b| and sign bits.
//   busy=1 in cycles E0..E32 (32 cycles). HI/LO written at E32.
//   done=1 for the single cycle E32..E33. Total latency is WIDTH+1 edges to done.
//  Sign handling:
//   mult/div use operand magnitudes; unsigned ops use raw values.
//   Result is negated at the final iteration when needed.
//  Multiply: radix-2 shift-add, one multiplier bit per cycle; 2*WIDTH-bit product -> {HI,LO}.
//  Divide: restoring, one quotient bit per cycle. LO=quotient, HI=remainder.
//   Quotient truncates toward zero; remainder sign follows the dividend.
//  Boundaries:
//   b==0 on div/divu: still 32 cycles; LO=all-ones; HI=a; dz=1 with done.
//   div 0x80000000 / 0xFFFFFFFF: LO=0x80000000; HI=0; dz=0.
//   mult 0x80000000 * 0x80000000: HI=0x40000000; LO=0.
//  Priority in IDLE/DONE:
//   start beats mthi/mtlo in the same cycle; the move is dropped.
//   mthi and mtlo together write both registers.
//  While busy: start, mthi, mtlo and a/b changes are ignored; hi/lo hold their old values until E32.
//  mthi/mtlo take effect at the next edge and raise no done.
//  dz=0 except in the DONE cycle of a zero-divisor divide. done never asserts without a prior start.
// TESTING
//  1 mult a=7 b=0xFFFFFFFD -> done exactly 33 edges after start; HI=0xFFFFFFFF LO=0xFFFFFFEB.
//  2 multu a=b=0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001; then div a=0xFFFFFFF9(-7) b=2
//    issued in the DONE cycle -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
//  3 divu a=5 b=0 -> LO=0xFFFFFFFF HI=5 dz=1 with done; next op gives dz=0.
//  4 div a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000 HI=0; divu a=100 b=7 -> LO=14 HI=2.
//  5 While busy: pulse start (op=multu), mthi wdata=0xDEAD, change a/b.
//    -> Ignored; first result intact, single done pulse.
//    Idle start+mtlo in the same cycle -> mtlo dropped.
//  6 Reset asserted asynchronously 10 cycles into a div.
//    -> busy/done/dz/hi/lo=0 immediately, no done pulse.
//    Post-reset mtlo 0x1234 -> lo=0x1234; a fresh mult completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit beside the ALU.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, results into HI/LO.
// Also serves the mthi/mtlo register moves while idle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {st_idle, st_mul, st_div, st_done} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;    // upper product half / partial remainder
  logic [WIDTH-1:0] low_q;    // multiplier shifting out / dividend in, quotient out
  logic [WIDTH-1:0] opnd_q;   // multiplicand / divisor magnitude
  logic             negq_q;   // negate product or quotient at the end
  logic             negr_q;   // negate remainder at the end (dividend sign)
  logic             dzp_q;    // zero divisor seen at launch

  // Operand magnitudes for the signed ops (op[0]=0); unsigned ops pass raw values.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // One iteration of each algorithm plus the sign-corrected final results.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc_n, mul_low_n;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_acc_n, div_low_n;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               last;

  // Operand conditioning and single-step datapath for multiply and divide.
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    mul_sum   = low_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
    mul_acc_n = mul_sum[WIDTH:1];
    mul_low_n = {mul_sum[0], low_q[WIDTH-1:1]};

    div_shift = {acc_q, low_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift - {1'b0, opnd_q};
    // Remainder stays below the divisor, so the top bit is always zero here.
    div_acc_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_low_n = {low_q[WIDTH-2:0], div_ge};

    prod     = {mul_acc_n, mul_low_n};
    prod_fix = negq_q ? -prod : prod;
    // Zero divisor: quotient forced to all-ones; remainder naturally equals the dividend.
    quot_fix = dzp_q ? '1 : (negq_q ? -div_low_n : div_low_n);
    rem_fix  = negr_q ? -div_acc_n : div_acc_n;
    last     = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM, working registers and HI/LO with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      opnd_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dzp_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      case (state_q)
        st_idle, st_done: begin
          if (start) begin
            // A launch wins over any move requested in the same cycle.
            state_q <= op[1] ? st_div : st_mul;
            busy    <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= '0;
            negq_q  <= a_neg ^ b_neg;
            if (op[1]) begin
              low_q  <= a_mag;
              opnd_q <= b_mag;
              negr_q <= a_neg;
              dzp_q  <= (b == '0);
            end else begin
              low_q  <= b_mag;
              opnd_q <= a_mag;
              negr_q <= 1'b0;
              dzp_q  <= 1'b0;
            end
          end else begin
            state_q <= st_idle;
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        st_mul: begin
          acc_q <= mul_acc_n;
          low_q <= mul_low_n;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            {hi, lo} <= prod_fix;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= st_done;
          end
        end
        st_div: begin
          acc_q <= div_acc_n;
          low_q <= div_low_n;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            lo      <= quot_fix;
            hi      <= rem_fix;
            dz      <= dzp_q;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= st_done;
          end
        end
        default: state_q <= st_idle;
      endcase
    end
  end

endmodule
